// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01011;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per step, MSB first.
module alu_divider #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // quo_q starts as the dividend and is shifted out MSB first as quotient bits shift in.
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_shift, trial;
  logic             fits;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign fits      = (rem_shift >= {1'b0, dvs_q});
  assign quotient  = {quo_q[WIDTH-2:0], fits};
  // After a step the remainder is below the divisor, so it always fits in WIDTH bits.
  assign remainder = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      quo_q <= quotient;
      rem_q <= remainder;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked integer ALU with start/done handshake; add/sub/mul in one cycle, div iterative.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_zero,
  output logic             ill_op
);

  state_t             state_q, state_d;
  logic               busy_d, done_d, carry_d, zero_d, div_zero_d, ill_op_d;
  logic [WIDTH-1:0]   out_d, out_hi_d;
  logic               div_load, div_step, div_last;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a),
    .divisor   (b),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy;
    done_d     = 1'b0;
    out_d      = out;
    out_hi_d   = out_hi;
    carry_d    = carry;
    zero_d     = zero;
    div_zero_d = div_zero;
    ill_op_d   = ill_op;
    div_load   = 1'b0;
    div_step   = 1'b0;

    unique case (state_q)
      IDLE: if (start) begin
        done_d     = 1'b1;
        carry_d    = 1'b0;
        out_hi_d   = '0;
        div_zero_d = 1'b0;
        ill_op_d   = 1'b0;
        case (s)
          OP_ADD: {carry_d, out_d} = sum;
          OP_SUB: begin
            out_d   = a - b;
            carry_d = (a < b);
          end
          OP_MUL: {out_hi_d, out_d} = prod;
          OP_DIV: begin
            if (b == '0) begin
              out_d      = '1;
              out_hi_d   = a;
              div_zero_d = 1'b1;
            end else begin
              // Flags and results keep their old values until the division completes.
              done_d     = 1'b0;
              out_hi_d   = out_hi;
              carry_d    = carry;
              div_zero_d = div_zero;
              ill_op_d   = ill_op;
              div_load   = 1'b1;
              busy_d     = 1'b1;
              state_d    = DIV;
            end
          end
          default: begin
            out_hi_d = out_hi;
            carry_d  = carry;
            ill_op_d = 1'b1;
          end
        endcase
      end
      DIV: begin
        div_step = 1'b1;
        if (div_last) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          out_d      = div_quo;
          out_hi_d   = div_rem;
          carry_d    = 1'b0;
          div_zero_d = 1'b0;
          ill_op_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_d && !ill_op_d) zero_d = (out_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      out_hi   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      div_zero <= 1'b0;
      ill_op   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      out      <= out_d;
      out_hi   <= out_hi_d;
      carry    <= carry_d;
      zero     <= zero_d;
      div_zero <= div_zero_d;
      ill_op   <= ill_op_d;
    end
  end

endmodule
